// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the general-purpose register file: default sizing,
// which the datapath and control FSM also use, and the bulk-clear sequencer
// state type.
// ---------------------------------------------------------------------------
package reg_file_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int NREGS_DEF = 8;
   localparam int NREAD_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/reg_file_sb_register_n.sv
// ---------------------------------------------------------------------------
// register_n
// Single WIDTH-bit storage register with load enable.
//   Clk       rising-edge clock
//   Reset     asynchronous active-high reset, clears Data_Out
//   Load      capture D at the next edge
//   D         next value
//   Data_Out  stored value
// ---------------------------------------------------------------------------
module register_n #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Data_Out
);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Data_Out <= '0;
      end else if (Load) begin
         Data_Out <= D;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Register file with NREAD combinational read ports, write-through bypass,
// a per-register busy scoreboard and a sequenced bulk clear.
//   Clk, Reset          clock, asynchronous active-high reset
//   LD_REG, DR, DATA    write-back port (clears busy[DR])
//   ISSUE, ISSUE_DR     mark a destination busy
//   CLEAR               start the zeroing sweep
//   SR / SR_OUT         packed read indices / packed read data
//   SR_BUSY             busy bit of each read port's register
//   CLR_BUSY, CLR_DONE  sweep in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | normal operation: writes, issues, bypass and CLEAR honoured
// SWEEP | zeroing reg[cnt] each cycle, all inputs ignored
// DONE  | one-cycle completion pulse, all inputs ignored
// ---------------------------------------------------------------------------
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int NREGS = NREGS_DEF,
   parameter  int NREAD = NREAD_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   LD_REG,
   input  logic [AW-1:0]          DR,
   input  logic [WIDTH-1:0]       DATA,
   input  logic                   ISSUE,
   input  logic [AW-1:0]          ISSUE_DR,
   input  logic                   CLEAR,
   input  logic [NREAD*AW-1:0]    SR,
   output logic [NREAD*WIDTH-1:0] SR_OUT,
   output logic [NREAD-1:0]       SR_BUSY,
   output logic                   CLR_BUSY,
   output logic                   CLR_DONE
);

   sweep_state_t     state_q, state_d;
   logic [AW-1:0]    cnt_q;
   logic [NREGS-1:0] busy_q, busy_d;
   logic [WIDTH-1:0] reg_q [NREGS];
   logic [WIDTH-1:0] wr_data;
   logic             idle, sweeping, cnt_last;

   assign idle     = (state_q == IDLE);
   assign sweeping = (state_q == SWEEP);
   assign cnt_last = (cnt_q == AW'(NREGS - 1));

   // The sweep shares the register load path; it only ever writes zero.
   assign wr_data = sweeping ? '0 : DATA;

   // ---------------- sweep FSM ----------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (CLEAR) state_d = SWEEP;
         SWEEP:   if (cnt_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counter wraps to 0 after the last register since NREGS is a power of two.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_q <= '0;
      end else if (idle && CLEAR) begin
         cnt_q <= '0;
      end else if (sweeping) begin
         cnt_q <= cnt_q + AW'(1);
      end
   end

   // ---------------- busy scoreboard ----------------
   // ISSUE is applied after LD_REG so a same-index pair ends busy.
   always_comb begin
      busy_d = busy_q;
      if (idle) begin
         if (CLEAR) begin
            busy_d = '0;
         end else begin
            if (LD_REG) busy_d[DR] = 1'b0;
            if (ISSUE)  busy_d[ISSUE_DR] = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // ---------------- storage ----------------
   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      logic load;
      assign load = (idle && LD_REG && (DR == AW'(i))) ||
                    (sweeping && (cnt_q == AW'(i)));

      register_n #(.WIDTH(WIDTH)) u_reg (
         .Clk      (Clk),
         .Reset    (Reset),
         .Load     (load),
         .D        (wr_data),
         .Data_Out (reg_q[i])
      );
   end

   // ---------------- read ports ----------------
   // Bypass forwards DATA only in IDLE; busy is never masked by bypass.
   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] idx;
      assign idx = SR[k*AW +: AW];
      assign SR_OUT[k*WIDTH +: WIDTH] = (idle && LD_REG && (DR == idx)) ? DATA : reg_q[idx];
      assign SR_BUSY[k] = busy_q[idx];
   end

   assign CLR_BUSY = sweeping;
   assign CLR_DONE = (state_q == DONE);

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   // default configuration: WIDTH=16, NREGS=8, NREAD=2
   logic        a_ld = 0, a_issue = 0, a_clear = 0;
   logic [2:0]  a_dr = 0, a_idr = 0;
   logic [15:0] a_data = 0;
   logic [5:0]  a_sr = 0;
   logic [31:0] a_out;
   logic [1:0]  a_busy;
   logic        a_cb, a_cd;

   // wide configuration: WIDTH=32, NREGS=16, NREAD=3
   logic        b_ld = 0, b_issue = 0, b_clear = 0;
   logic [3:0]  b_dr = 0, b_idr = 0;
   logic [31:0] b_data = 0;
   logic [11:0] b_sr = 0;
   logic [95:0] b_out;
   logic [2:0]  b_busy;
   logic        b_cb, b_cd;

   int checks = 0;
   int failures = 0;

   reg_file_sb dut_a (
      .Clk(Clk), .Reset(Reset), .LD_REG(a_ld), .DR(a_dr), .DATA(a_data),
      .ISSUE(a_issue), .ISSUE_DR(a_idr), .CLEAR(a_clear), .SR(a_sr),
      .SR_OUT(a_out), .SR_BUSY(a_busy), .CLR_BUSY(a_cb), .CLR_DONE(a_cd)
   );

   reg_file_sb #(.WIDTH(32), .NREGS(16), .NREAD(3)) dut_b (
      .Clk(Clk), .Reset(Reset), .LD_REG(b_ld), .DR(b_dr), .DATA(b_data),
      .ISSUE(b_issue), .ISSUE_DR(b_idr), .CLEAR(b_clear), .SR(b_sr),
      .SR_OUT(b_out), .SR_BUSY(b_busy), .CLR_BUSY(b_cb), .CLR_DONE(b_cd)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Behavioural model of dut_a: contents, busy set, and a count of
   // sweep cycles still to run (registers cleared in ascending order).
   logic [15:0] m_reg [8] = '{default: 16'h0};
   logic [7:0]  m_busy = 8'h0;
   int          m_left = 0;
   bit          m_done = 0;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
         m_busy = 8'h0;
         m_left = 0;
         m_done = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_left > 0) begin
         m_reg[8 - m_left] = 16'h0;
         m_left--;
         if (m_left == 0) m_done = 1;
      end else begin
         if (a_ld) begin
            m_reg[a_dr] = a_data;
            m_busy[a_dr] = 1'b0;
         end
         if (a_issue) m_busy[a_idr] = 1'b1;
         if (a_clear) begin
            m_busy = 8'h0;
            m_left = 8;
         end
      end
   end

   always @(negedge Clk) begin : compare
      logic [31:0] e_out;
      logic [1:0]  e_busy;
      logic [2:0]  s;
      bit          m_idle;
      m_idle = (m_left == 0) && !m_done;
      for (int k = 0; k < 2; k++) begin
         s = a_sr[k*3 +: 3];
         e_out[k*16 +: 16] = (m_idle && a_ld && a_dr == s) ? a_data : m_reg[s];
         e_busy[k] = m_busy[s];
      end
      chk("model_sr_out", a_out, e_out);
      chk("model_sr_busy", a_busy, e_busy);
      chk("model_clr_busy", a_cb, m_left > 0);
      chk("model_clr_done", a_cd, m_done);
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int n;
      // ---------- reset state ----------
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_out_a", a_out, 0);
      chk("rst_busy_a", a_busy, 0);
      chk("rst_cb_a", a_cb, 0);
      chk("rst_cd_a", a_cd, 0);
      chk("rst_out_b", b_out, 0);
      Reset = 0;
      step();

      // ---------- reset mid-operation ----------
      a_ld = 1; a_dr = 3; a_data = 16'hBEEF; a_issue = 1; a_idr = 3;
      step();
      a_ld = 0; a_issue = 0; a_sr = {3'd0, 3'd3};
      #1;
      chk("r3_beef", a_out[15:0], 16'hBEEF);
      chk("r3_busy", a_busy[0], 1'b1);
      #1 Reset = 1;
      #1;
      chk("async_rst_out", a_out[15:0], 16'h0);
      chk("async_rst_busy", a_busy, 2'b00);
      #4 Reset = 0;
      step();

      // ---------- write and bypass ----------
      a_ld = 1; a_dr = 5; a_data = 16'h1234; a_sr = {3'd5, 3'd5};
      #1;
      chk("bypass_both", a_out, 32'h1234_1234);
      step();
      a_ld = 0;
      #1;
      chk("stored_both", a_out, 32'h1234_1234);

      // ---------- scoreboard ----------
      a_issue = 1; a_idr = 2; a_sr = {3'd2, 3'd2};
      #1;
      chk("issue_not_yet", a_busy, 2'b00);
      step();
      a_issue = 0;
      a_ld = 1; a_dr = 2; a_data = 16'h00AA;
      #1;
      chk("busy_after_issue", a_busy, 2'b11);
      chk("bypass_busy_out", a_out, 32'h00AA_00AA);
      step();
      a_ld = 0;
      #1;
      chk("busy_cleared", a_busy, 2'b00);
      chk("r2_aa", a_out[15:0], 16'h00AA);
      a_ld = 1; a_dr = 2; a_data = 16'h0055; a_issue = 1; a_idr = 2;
      step();
      a_ld = 0; a_issue = 0;
      #1;
      chk("same_idx_data", a_out[15:0], 16'h0055);
      chk("same_idx_busy", a_busy, 2'b11);
      a_ld = 1; a_dr = 7; a_data = 16'h7777; a_issue = 1; a_idr = 6;
      step();
      a_ld = 0; a_issue = 0; a_sr = {3'd7, 3'd6};
      #1;
      chk("diff_idx_busy", a_busy, 2'b01);
      chk("diff_idx_data", a_out[31:16], 16'h7777);

      // ---------- sweep ----------
      for (int i = 0; i < 8; i++) begin
         a_ld = 1; a_dr = 3'(i); a_data = 16'(16'h1111 * (i + 1));
         a_issue = (i == 7); a_idr = 4;
         step();
      end
      a_ld = 0; a_issue = 0; a_sr = {3'd4, 3'd7};
      #1;
      chk("r7_8888", a_out[15:0], 16'h8888);
      chk("r4_busy_pre", a_busy, 2'b10);
      a_clear = 1;
      step();
      a_clear = 0; a_sr = {3'd7, 3'd0};
      n = 0;
      while (a_cb && n < 40) begin
         n++;
         step();
         if (n == 1) begin
            chk("sweep_r0_zero", a_out[15:0], 16'h0);
            chk("sweep_r7_kept", a_out[31:16], 16'h8888);
            a_ld = 1; a_dr = 1; a_data = 16'hFFFF;
            a_issue = 1; a_idr = 4; a_clear = 1;
         end
      end
      chk("sweep_len_a", n, 8);
      chk("done_pulse", a_cd, 1'b1);
      step();
      a_ld = 0; a_issue = 0; a_clear = 0;
      #1;
      chk("done_once", a_cd, 1'b0);
      chk("no_resweep", a_cb, 1'b0);
      for (int i = 0; i < 8; i += 2) begin
         a_sr = {3'(i + 1), 3'(i)};
         #1;
         chk("all_zero", a_out, 32'h0);
         chk("all_idle", a_busy, 2'b00);
      end
      step();
      chk("still_idle", a_cb, 1'b0);

      // ---------- reset during sweep ----------
      a_ld = 1; a_dr = 6; a_data = 16'hCAFE;
      step();
      a_ld = 0; a_clear = 1;
      step();
      a_clear = 0;
      step();
      #1 Reset = 1;
      #1;
      chk("sweep_rst_cb", a_cb, 1'b0);
      #4 Reset = 0;
      step();
      chk("sweep_rst_cd", a_cd, 1'b0);

      // ---------- wide configuration ----------
      b_ld = 1; b_dr = 3;  b_data = 32'hA5A5_0003; step();
      b_dr = 9;  b_data = 32'h1234_5678; step();
      b_dr = 15; b_data = 32'hDEAD_BEEF; step();
      b_ld = 0; b_sr = {4'd15, 4'd9, 4'd3};
      #1;
      chk("wide_read", b_out, {32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_0003});
      b_sr = {4'd3, 4'd15, 4'd9};
      #1;
      chk("wide_read_perm", b_out, {32'hA5A5_0003, 32'hDEAD_BEEF, 32'h1234_5678});
      b_clear = 1;
      step();
      b_clear = 0;
      n = 0;
      while (b_cb && n < 40) begin
         n++;
         step();
      end
      chk("sweep_len_b", n, 16);
      chk("done_b", b_cd, 1'b1);
      step();
      chk("wide_zero", b_out, 96'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised LC-3-style general-purpose register file with N read ports, write-through bypass, a per-register busy scoreboard and a sequenced bulk clear. It sits between the datapath bus (DATA) and the ALU/address units. It supports multi-cycle operations: the control FSM marks a destination pending at issue, and the write-back retires it.

## Interface
- WIDTH, 16, data width of each register
- NREGS, 8, number of registers (power of two, ≥2); AW = $clog2(NREGS)
- NREAD, 2, number of independent read ports
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- LD_REG  in  1  write enable for register DR this cycle
- DR  in  AW  write-back destination index
- DATA  in  WIDTH  write-back data
- ISSUE  in  1  mark register ISSUE_DR busy (op in flight)
- ISSUE_DR  in  AW  index to mark busy
- CLEAR  in  1  start bulk zeroing sweep (pulse; level tolerated)
- SR  in  NREAD*AW  read indices; port k uses bits [k*AW +: AW]
- SR_OUT  out  NREAD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
- SR_BUSY  out  NREAD  port k's register is busy
- CLR_BUSY  out  1  sweep in progress
- CLR_DONE  out  1  one-cycle pulse when sweep completes

## Operation
- Reset (async, any time, including mid-sweep): all registers 0, all busy bits 0, FSM IDLE, sweep counter 0. Outputs then read 0, SR_BUSY 0, CLR_BUSY 0, CLR_DONE 0.
- Write: in IDLE, LD_REG=1 loads DATA into reg[DR] at the next edge and clears busy[DR].
- Read: SR_OUT[k] is combinational from reg[SR[k]].
  - Bypass: in IDLE with LD_REG=1 and SR[k]==DR, SR_OUT[k]=DATA (same cycle).
  - Any number of ports may address the same register.
- Scoreboard: in IDLE, ISSUE=1 sets busy[ISSUE_DR] at the next edge.
  - ISSUE to an already-busy register leaves it busy. No counting; a single LD_REG clears it.
  - ISSUE and LD_REG to the same index in the same cycle: data written, busy ends 1 (issue is the newer op).
  - ISSUE and LD_REG to different indices: both take effect.
  - SR_BUSY[k] = busy[SR[k]] as registered. Bypass does not mask it; a busy register being written this cycle still reports busy until the edge.
- FSM states IDLE, SWEEP, DONE:
  - IDLE -> SWEEP when CLEAR=1. On that edge all busy bits clear and the counter is set to 0.
  - SWEEP: each cycle reg[cnt] <= 0 and cnt increments. After the edge writing reg[NREGS-1] (cnt wraps to 0), go to DONE. The sweep lasts exactly NREGS cycles.
  - DONE: CLR_DONE=1 for one cycle, then IDLE. A CLEAR seen in DONE is ignored; a new CLEAR is accepted from IDLE only.
  - In SWEEP and DONE, LD_REG, ISSUE and CLEAR are ignored and bypass is disabled. Reads return stored contents, which are partially cleared during the sweep.
- CLR_BUSY = (state == SWEEP).

## Timing
- Read latency 0 cycles (combinational). Write and busy-update latency 1 edge.
- CLEAR accepted at edge t → CLR_BUSY high for cycles t+1 … t+NREGS, CLR_DONE high at cycle t+NREGS+1, and IDLE plus inputs honoured again from t+NREGS+2.
- No combinational path from CLEAR to any output. CLR_BUSY and CLR_DONE are decoded from registered state.
- Reset deassertion takes effect at the first following edge; no output glitches are required to be suppressed.

## Structure
- Package reg_file_pkg:
  - sweep_state_t enum {IDLE, SWEEP, DONE}
  - Default localparams for WIDTH/NREGS/NREAD, shared with the datapath and control FSM.
- Sub-module register_n:
  - Parameter WIDTH; ports Clk, Reset (async high), Load, D, Data_Out.
  - Instantiated NREGS times via generate. The D mux selects DATA or 0 (sweep), and Load = write-decode | sweep-hit.
- Busy vector, sweep counter and FSM live in the top level. Read muxing is a generate loop over NREAD.

## Test plan
- Reset mid-operation: write 0xBEEF to R3, assert Reset asynchronously between edges → SR_OUT immediately 0 for SR=3, SR_BUSY=0.
- Write/bypass: LD_REG=1, DR=5, DATA=0x1234, SR port0=5, port1=5 → both ports read 0x1234 in the same cycle, and both still read 0x1234 after the edge with LD_REG=0.
- Scoreboard:
  - ISSUE R2 → SR_BUSY=1 from next cycle.
  - Later LD_REG R2 0x00AA → busy 0 after that edge.
  - Simultaneous ISSUE R2 + LD_REG R2 0x0055 → data 0x0055, busy stays 1.
- Sweep (NREGS=8):
  - Fill R0–R7 with 0x1111·(i+1), pulse CLEAR → CLR_BUSY for exactly 8 cycles; R0 reads 0 after the first sweep edge while R7 still reads 0x8888.
  - CLR_DONE pulses once; all registers 0 and all busy bits 0 at the end.
- Ignore-during-sweep: LD_REG R1 0xFFFF, ISSUE R4 and CLEAR during SWEEP and DONE → no effect; R1 reads 0, R4 not busy, no second sweep.
- Parameter sweep: WIDTH=32, NREGS=16, NREAD=3 → all three ports read independent indices correctly, and the sweep takes 16 cycles.
